// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sequencer sharing one square-root core among N_REQ requesters.
// The core is started by releasing its reset, so core_rst_n_o is the launch strobe.
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [16*N_REQ-1:0]        req_valor_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       rsp_valid_o,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
    output logic [7:0]                 rsp_root_o,
    output logic                       rsp_err_o,
    input  logic                       rsp_ready_i,
    output logic                       core_rst_n_o,
    output logic [15:0]                core_valor_o,
    input  logic                       core_ready_i,
    input  logic [7:0]                 core_root_i,
    output logic                       busy_o
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr, gnt, gnt_nxt, off;
    logic [IDW:0]   sum;
    logic [N_REQ-1:0] rot;
    logic [15:0]    gnt_valor;
    logic [CW-1:0]  cnt;

    // Rotate valids so index 0 is the pointer, then take the lowest set bit.
    always_comb begin
        rot = N_REQ'({req_valid_i, req_valid_i} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IDW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        gnt = IDW'(sum >= (IDW+1)'(N_REQ) ? sum - (IDW+1)'(N_REQ) : sum);
        gnt_nxt = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
        gnt_valor = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt == IDW'(i)) gnt_valor = req_valor_i[16*i +: 16];
    end

    assign req_ready_o  = (state == IDLE && rst_n && |req_valid_i) ? N_REQ'(1) << gnt : '0;
    assign rsp_valid_o  = state == RESP;
    assign busy_o       = state != IDLE;
    assign core_rst_n_o = state == RUN || state == RESP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            rsp_id_o     <= '0;
            rsp_root_o   <= '0;
            rsp_err_o    <= 1'b0;
            core_valor_o <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid_i) begin
                    core_valor_o <= gnt_valor;
                    rsp_id_o     <= gnt;
                    ptr          <= gnt_nxt;
                    state        <= LAUNCH;
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                    // Ready during the first two RUN cycles is stale boot noise.
                    if (cnt >= CW'(2) && core_ready_i) begin
                        rsp_root_o <= core_root_i;
                        rsp_err_o  <= 1'b0;
                        state      <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        rsp_root_o <= '0;
                        rsp_err_o  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed table, corner sequences and random traffic against a rule-level model.
module tb_sqrt_arbiter;
    localparam int N  = 4;
    localparam int TO = 10;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_valor = '0;
    logic        rsp_ready = 1;
    logic        core_ready = 0;
    logic [7:0]  core_root;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_err, core_rst_n, busy;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_root;
    logic [15:0] core_valor;

    logic [63:0] pat = '0;
    int          k = -1;
    int          total = 0, bad = 0;
    bit          pend [N];
    logic [15:0] opv [N];
    int          ptr_m = 0;

    typedef struct {
        int          id;
        logic [15:0] v;
        logic [63:0] p;
        int          stall;
        int          root;
        int          err;
        int          lat;
    } vec_t;
    vec_t tv [10];

    sqrt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_valor_i(req_valor), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_root_o(rsp_root), .rsp_err_o(rsp_err),
        .rsp_ready_i(rsp_ready),
        .core_rst_n_o(core_rst_n), .core_valor_o(core_valor),
        .core_ready_i(core_ready), .core_root_i(core_root),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Core model: k counts cycles since the core left reset; ready follows the pattern.
    assign core_root = 8'(isqrt(int'(core_valor)));
    always @(negedge clk) begin
        k = core_rst_n ? k + 1 : -1;
        core_ready = (k >= 0 && k < 64) ? pat[k] : 1'b0;
    end

    // RUN cycles until ready is honoured, or -1 for a timeout.
    function automatic int exp_c(input logic [63:0] p);
        for (int i = 2; i <= TO; i++)
            if (p[i]) return i + 1;
        return -1;
    endfunction

    function automatic int pick();
        for (int i = 0; i < N; i++)
            if (pend[(ptr_m + i) % N]) return (ptr_m + i) % N;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic raise(input int id, input logic [15:0] v);
        req_valid[id] = 1'b1;
        req_valor[16*id +: 16] = v;
        pend[id] = 1'b1;
        opv[id] = v;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic serve(input int id, input logic [63:0] p, input int stall,
                         input int er, input int ee, input int el);
        int n;
        pat = p;
        rsp_ready = (stall == 0);
        #1;
        n = 0;
        while (req_ready == 0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("grant", req_ready, 32'(1) << id);
        check("idle_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        pend[id] = 1'b0;
        ptr_m = (id + 1) % N;
        check("launch_core_rst", core_rst_n, 0);
        check("launch_ready", req_ready, 0);
        n = 1;
        while (!rsp_valid && n < TO + 10) begin
            @(negedge clk); n++;
        end
        check("latency", n, el);
        check("rsp_id", rsp_id, id);
        check("rsp_root", rsp_root, er);
        check("rsp_err", rsp_err, ee);
        check("resp_core_rst", core_rst_n, 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_id", rsp_id, id);
            check("hold_root", rsp_root, er);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("back_idle", rsp_valid, 0);
        check("back_busy", busy, 0);
    endtask

    task automatic serve_next(input logic [63:0] p, input int stall);
        int g, c;
        g = pick();
        c = exp_c(p);
        serve(g, p, stall, c < 0 ? 0 : isqrt(int'(opv[g])), c < 0 ? 1 : 0, c < 0 ? TO + 3 : 2 + c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] p;
        int n;
        for (int i = 0; i < N; i++) begin pend[i] = 0; opv[i] = 0; end
        tv[0] = '{0, 16'd144,   64'h80,  0,  12,  0, 10};
        tv[1] = '{1, 16'd0,     64'h4,   0,  0,   0, 5};
        tv[2] = '{2, 16'd10000, 64'h43,  0,  100, 0, 9};
        tv[3] = '{3, 16'd50,    64'h0,   0,  0,   1, 13};
        tv[4] = '{0, 16'd65535, '1,      0,  255, 0, 5};
        tv[5] = '{1, 16'd2,     64'h400, 0,  1,   0, 13};
        tv[6] = '{2, 16'd99,    64'h800, 0,  0,   1, 13};
        tv[7] = '{3, 16'd143,   64'h8,   0,  11,  0, 6};
        tv[8] = '{1, 16'd400,   64'h10,  20, 20,  0, 7};
        tv[9] = '{0, 16'd15,    64'h5,   1,  3,   0, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_root", rsp_root, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_core_rst", core_rst_n, 0);
        check("rst_core_valor", core_valor, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round robin: 1 and 3 from ptr 0, then 2 alone moves ptr to 3, so 3 beats 1.
        raise(1, 16'd81);
        raise(3, 16'd16);
        serve(1, 64'h4, 0, 9, 0, 5);
        serve(3, 64'h4, 0, 4, 0, 5);
        raise(2, 16'd25);
        serve(2, 64'h4, 0, 5, 0, 5);
        raise(1, 16'd36);
        raise(3, 16'd49);
        serve(3, 64'h4, 0, 7, 0, 5);
        serve(1, 64'h4, 0, 6, 0, 5);

        for (int i = 0; i < 10; i++) begin
            raise(tv[i].id, tv[i].v);
            serve(tv[i].id, tv[i].p, tv[i].stall, tv[i].root, tv[i].err, tv[i].lat);
        end

        // Reset during RUN with req1 in flight and req3 waiting.
        raise(1, 16'd1000);
        pat = '0;
        #1;
        n = 0;
        while (req_ready == 0 && n < 20) begin @(negedge clk); #1; n++; end
        check("mid_grant", req_ready, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        pend[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1);
        raise(3, 16'd7);
        rst_n = 1'b0;
        #1;
        check("mid_req_ready", req_ready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_rsp_id", rsp_id, 0);
        check("mid_rsp_root", rsp_root, 0);
        check("mid_rsp_err", rsp_err, 0);
        check("mid_core_rst", core_rst_n, 0);
        check("mid_core_valor", core_valor, 0);
        check("mid_busy_rst", busy, 0);
        @(negedge clk);
        req_valid[3] = 1'b0;
        pend[3] = 1'b0;
        rst_n = 1'b1;
        ptr_m = 0;
        raise(0, 16'd9);
        raise(2, 16'd65535);
        serve(0, 64'h4, 0, 3, 0, 5);
        serve(2, 64'h4, 0, 255, 0, 5);

        for (int r = 0; r < 60; r++) begin
            for (int j = 0; j < N; j++)
                if (!pend[j] && $urandom_range(0, 2) == 0) raise(j, 16'($urandom));
            if (pick() < 0) raise(int'($urandom_range(0, N - 1)), 16'($urandom));
            case ($urandom_range(0, 3))
                0: p = '0;
                1: p = (64'(1) << $urandom_range(0, 12)) | 64'h3;
                default: p = 64'(1) << $urandom_range(0, 12);
            endcase
            serve_next(p, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 5)) : 0);
        end
        while (pick() >= 0) serve_next(64'h4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
